hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It consumes the per-instruction use/produce timing decoded in D, and tracks every in-flight destination register through E, M and W together with its remaining cycles-to-result (Tnew). From that state it drives the global stall and the forwarding mux selects at D, E and M. It also sequences the multiply/divide unit's busy window, stalling HI/LO users until the unit finishes.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu enters E
- DIV_CYC, 10, busy cycles after a div/divu enters E

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs_d, rt_d  in  5 each  source register numbers of the instruction in D
- tuse_rs, tuse_rt  in  2 each  cycles from D until the operand is needed; 3 means the operand is unused
- a3_d  in  5  destination register of the D instruction; 0 means no write
- tnew_d  in  2  cycles from E entry until the result exists: pc=0, alu=1, dm=2, other=1
- md_d  in  1  D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- md_start_d  in  2  00 none, 01 mult-class, 10 div-class
- flush  in  1  exception/eret flush; kills E, M and W records
- stall  out  1  freeze PC and D, inject a bubble into E
- fwd_rs_d, fwd_rt_d  out  2 each  D-stage operand source: 0 GRF, 1 E, 2 M, 3 W
- fwd_rs_e, fwd_rt_e  out  2 each  E-stage operand source: 0 latched, 2 M, 3 W (1 is never driven)
- fwd_rt_m  out  2  M-stage store data source: 0 latched, 3 W
- md_busy  out  1  MD unit counter non-zero

## Operation
- Records (registered):
  - E: a3_e, tnew_e, rs_e, rt_e, start_e
  - M: a3_m, tnew_m, rt_m
  - W: a3_w
- Advance each edge:
  - If stall=0, E loads the D fields. If stall=1, E loads a bubble (all fields 0).
  - M loads E, with tnew decremented and saturating at 0.
  - W loads a3_m.
- Flush: the next edge zeroes the E, M and W records and start_e. A running MD counter keeps counting.
- Register 0 never matches: a3=0 or a source of 0 produces no stall and no forward.
- Stall for rs, when tuse_rs≠3 and rs_d≠0:
  - a3_e=rs_d and tnew_e>tuse_rs, or
  - a3_m=rs_d and (tnew_e−1 saturated value held in M) tnew_m>tuse_rs.
- Stall for rt is the same rule using rt_d and tuse_rt.
- MD stall: md_d=1 and (md_busy=1 or start_e≠0).
- stall is the OR of the rs, rt and MD stall terms.
- Forward priority is nearest stage first. A stage is eligible only if its a3 matches and its tnew=0; W always has tnew=0.
  - D selects: E, then M, then W, else GRF.
  - E selects: M, then W, else latched.
  - M select: W, else latched.
- MD counter, md_cnt (4 bits):
  - When an instruction with md_start_d≠0 enters E (stall=0, flush=0), md_cnt loads MULT_CYC or DIV_CYC on that edge.
  - Otherwise md_cnt decrements if non-zero.
  - md_busy = (md_cnt≠0).
- A new MD start while the counter is non-zero cannot occur, because MD instructions stall on busy.

## Timing
- All outputs are combinational from registered records plus the D inputs. There is no added latency.
- Reset (reset_n=0, asynchronous) clears every record and md_cnt immediately. All outputs then read 0: stall=0, all selects 0, md_busy=0.
- Reset released mid-operation: all records restart empty. No stale stall or forward survives.
- stall and flush asserted together: flush wins for the E record (bubble) and suppresses MD counter load.

## Test plan
- lw $1 in E (tnew 2), addu $2,$1,$1 in D (tuse 1) -> stall=1 for exactly 1 cycle. Next cycle stall=0. When addu is in E, fwd_rs_e=fwd_rt_e=3.
- addu $3 in E, beq $3,$0 in D (tuse 0) -> stall=1 for 1 cycle. Then fwd_rs_d=2, fwd_rt_d=0.
- jal (a3=31, tnew 0) in E, jr $31 in D -> stall=0, fwd_rs_d=1. Producer writing $0 with a reader of $0 -> stall=0, selects 0.
- lw $4 in W, sw $4 in M -> fwd_rt_m=3. sw $4 in D behind lw $4 in E (tuse_rt 2, tnew 2) -> stall=0.
- mult enters E, then mflo in D -> md_busy=1 and stall=1 for 5 cycles (md_cnt 5..1), then stall=0. With div, the stall lasts 10 cycles.
- div running with md_cnt=7: pulse flush -> records cleared, md_cnt keeps counting. Drop reset_n -> md_busy=0 and stall=0 within the same cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for the 5-stage MIPS pipeline. Tracks
// in-flight destinations with their cycles-to-result, and the multiply/divide busy window.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic [4:0] a3_d,
  input  logic [1:0] tnew_d,
  input  logic       md_d,
  input  logic [1:0] md_start_d,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic [1:0] fwd_rt_m,
  output logic       md_busy
);

  logic [4:0] a3_e_r, rs_e_r, rt_e_r;
  logic [1:0] tnew_e_r, start_e_r;
  logic [4:0] a3_m_r, rt_m_r;
  logic [1:0] tnew_m_r;
  logic [4:0] a3_w_r;
  logic [3:0] md_cnt_r;

  logic       stall_rs_s, stall_rt_s, stall_md_s;
  logic       md_load_s;
  logic [3:0] md_load_val_s;

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                      input logic [4:0] m_a3, input logic [1:0] m_tnew);
    return (tuse != 2'd3) && (src != 5'd0) &&
           (((e_a3 == src) && (e_tnew > tuse)) || ((m_a3 == src) && (m_tnew > tuse)));
  endfunction

  // Nearest eligible producer wins; passing a3=0 disables a stage since src 0 never matches.
  function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                            input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                            input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                            input logic [4:0] w_a3);
    logic [1:0] sel;
    if (src == 5'd0) begin
      sel = 2'd0;
    end else if ((e_a3 == src) && (e_tnew == 2'd0)) begin
      sel = 2'd1;
    end else if ((m_a3 == src) && (m_tnew == 2'd0)) begin
      sel = 2'd2;
    end else if (w_a3 == src) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign stall_rs_s = src_hazard(rs_d, tuse_rs, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
  assign stall_rt_s = src_hazard(rt_d, tuse_rt, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
  assign stall_md_s = md_d && ((md_cnt_r != 4'd0) || (start_e_r != 2'd0));
  assign stall      = stall_rs_s || stall_rt_s || stall_md_s;
  assign md_busy    = (md_cnt_r != 4'd0);

  assign fwd_rs_d = fwd_select(rs_d,   a3_e_r, tnew_e_r, a3_m_r, tnew_m_r, a3_w_r);
  assign fwd_rt_d = fwd_select(rt_d,   a3_e_r, tnew_e_r, a3_m_r, tnew_m_r, a3_w_r);
  assign fwd_rs_e = fwd_select(rs_e_r, 5'd0,   2'd0,     a3_m_r, tnew_m_r, a3_w_r);
  assign fwd_rt_e = fwd_select(rt_e_r, 5'd0,   2'd0,     a3_m_r, tnew_m_r, a3_w_r);
  assign fwd_rt_m = fwd_select(rt_m_r, 5'd0,   2'd0,     5'd0,   2'd0,     a3_w_r);

  // MD counter load value, chosen by the class of the instruction entering E.
  always_comb begin
    md_load_val_s = 4'd0;
    md_load_s     = 1'b0;
    case (md_start_d)
      2'b01: begin
        md_load_val_s = 4'(MULT_CYC);
        md_load_s     = !stall && !flush;
      end
      2'b10: begin
        md_load_val_s = 4'(DIV_CYC);
        md_load_s     = !stall && !flush;
      end
      default: begin
        md_load_val_s = 4'd0;
        md_load_s     = 1'b0;
      end
    endcase
  end

  // Pipeline records: E takes D or a bubble, M/W shift forward, flush empties all three.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a3_e_r    <= 5'd0;
      rs_e_r    <= 5'd0;
      rt_e_r    <= 5'd0;
      tnew_e_r  <= 2'd0;
      start_e_r <= 2'd0;
      a3_m_r    <= 5'd0;
      rt_m_r    <= 5'd0;
      tnew_m_r  <= 2'd0;
      a3_w_r    <= 5'd0;
    end else begin
      if (flush || stall) begin
        a3_e_r    <= 5'd0;
        rs_e_r    <= 5'd0;
        rt_e_r    <= 5'd0;
        tnew_e_r  <= 2'd0;
        start_e_r <= 2'd0;
      end else begin
        a3_e_r    <= a3_d;
        rs_e_r    <= rs_d;
        rt_e_r    <= rt_d;
        tnew_e_r  <= tnew_d;
        start_e_r <= md_start_d;
      end
      if (flush) begin
        a3_m_r   <= 5'd0;
        rt_m_r   <= 5'd0;
        tnew_m_r <= 2'd0;
        a3_w_r   <= 5'd0;
      end else begin
        a3_m_r   <= a3_e_r;
        rt_m_r   <= rt_e_r;
        tnew_m_r <= (tnew_e_r == 2'd0) ? 2'd0 : (tnew_e_r - 2'd1);
        a3_w_r   <= a3_m_r;
      end
    end
  end

  // MD busy counter; keeps counting through a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_r <= 4'd0;
    end else if (md_load_s) begin
      md_cnt_r <= md_load_val_s;
    end else if (md_cnt_r != 4'd0) begin
      md_cnt_r <= md_cnt_r - 4'd1;
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then random instruction streams,
// checked against an age-based model of in-flight producers and an MD finish time.
module tb_hazard_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs_d, rt_d, a3_d;
  logic [1:0] tuse_rs, tuse_rt, tnew_d, md_start_d;
  logic       md_d, flush;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs),
    .tuse_rt(tuse_rt), .a3_d(a3_d), .tnew_d(tnew_d), .md_d(md_d), .md_start_d(md_start_d),
    .flush(flush), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // An in-flight instruction: its result is ready tnew0 cycles after it entered E.
  typedef struct {
    logic [4:0] a3;
    logic [4:0] rs;
    logic [4:0] rt;
    int         tnew0;
    int         enter;
    logic [1:0] start;
  } rec_t;

  rec_t re, rm, rw;
  int   cyc, md_done;
  int   vectors, miscompares;
  logic       x_stall, x_busy;
  logic [1:0] x_frd, x_ftd, x_fre, x_fte, x_ftm;

  function automatic rec_t empty(input int c);
    rec_t r;
    r = '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tnew0: 0, enter: c, start: 2'd0};
    return r;
  endfunction

  function automatic int remaining(input rec_t r, input int now);
    int v;
    v = r.tnew0 - (now - r.enter);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic logic hz(input logic [4:0] s, input logic [1:0] u);
    if (u == 2'd3 || s == 5'd0) return 1'b0;
    if (re.a3 == s && remaining(re, cyc) > int'(u)) return 1'b1;
    if (rm.a3 == s && remaining(rm, cyc) > int'(u)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_of(input logic [4:0] s, input logic use_e, input logic use_m);
    if (s == 5'd0) return 2'd0;
    if (use_e && re.a3 == s && remaining(re, cyc) == 0) return 2'd1;
    if (use_m && rm.a3 == s && remaining(rm, cyc) == 0) return 2'd2;
    if (rw.a3 == s) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_eval();
    x_busy  = (cyc < md_done);
    x_stall = hz(rs_d, tuse_rs) || hz(rt_d, tuse_rt) || (md_d && (x_busy || re.start != 2'd0));
    x_frd   = src_of(rs_d, 1'b1, 1'b1);
    x_ftd   = src_of(rt_d, 1'b1, 1'b1);
    x_fre   = src_of(re.rs, 1'b0, 1'b1);
    x_fte   = src_of(re.rt, 1'b0, 1'b1);
    x_ftm   = src_of(rm.rt, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare();
    model_eval();
    chk("stall",    {3'd0, stall},   {3'd0, x_stall});
    chk("md_busy",  {3'd0, md_busy}, {3'd0, x_busy});
    chk("fwd_rs_d", {2'd0, fwd_rs_d}, {2'd0, x_frd});
    chk("fwd_rt_d", {2'd0, fwd_rt_d}, {2'd0, x_ftd});
    chk("fwd_rs_e", {2'd0, fwd_rs_e}, {2'd0, x_fre});
    chk("fwd_rt_e", {2'd0, fwd_rt_e}, {2'd0, x_fte});
    chk("fwd_rt_m", {2'd0, fwd_rt_m}, {2'd0, x_ftm});
  endtask

  task automatic advance();
    model_eval();
    cyc++;
    if (md_start_d != 2'd0 && !x_stall && !flush)
      md_done = cyc + ((md_start_d == 2'b01) ? MULT_CYC : DIV_CYC);
    rw.a3 = flush ? 5'd0 : rm.a3;
    rm    = flush ? empty(cyc) : re;
    if (flush || x_stall) re = empty(cyc);
    else re = '{a3: a3_d, rs: rs_d, rt: rt_d, tnew0: int'(tnew_d), enter: cyc, start: md_start_d};
  endtask

  task automatic tick();
    compare();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                       input logic [1:0] urt, input logic [4:0] a3, input logic [1:0] tn,
                       input logic md, input logic [1:0] st);
    rs_d = rs; rt_d = rt; tuse_rs = urs; tuse_rt = urt;
    a3_d = a3; tnew_d = tn; md_d = md; md_start_d = st;
    #1;
  endtask

  // Asynchronous reset pulse inside the low clock phase; outputs must clear at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    re = empty(cyc); rm = empty(cyc); rw = empty(cyc); md_done = 0;
    chk("rst_stall", {3'd0, stall},   4'd0);
    chk("rst_busy",  {3'd0, md_busy}, 4'd0);
    compare();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; md_done = 0;
    re = empty(0); rm = empty(0); rw = empty(0);
    reset_n = 1'b0; flush = 1'b0;
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0);
    #1;
    compare();
    chk("reset_stall", {3'd0, stall}, 4'd0);
    chk("reset_fwd",   {2'd0, fwd_rs_d}, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // lw $1 then dependent addu: one stall, then W forward in E
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 2'd0); tick();
    set_d(5'd1, 5'd1, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 2'd0);
    chk("lw_use_stall", {3'd0, stall}, 4'd1); tick();
    chk("lw_use_release", {3'd0, stall}, 4'd0); tick();
    chk("addu_fwd_rs_e", {2'd0, fwd_rs_e}, 4'd3);
    chk("addu_fwd_rt_e", {2'd0, fwd_rt_e}, 4'd3);

    // addu $3 then beq $3,$0
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 2'd0); tick();
    set_d(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0);
    chk("beq_stall", {3'd0, stall}, 4'd1); tick();
    chk("beq_release", {3'd0, stall}, 4'd0);
    chk("beq_fwd_rs_d", {2'd0, fwd_rs_d}, 4'd2);
    chk("beq_fwd_rt_d", {2'd0, fwd_rt_d}, 4'd0); tick();

    // jal / jr $31, then $0 producer and reader
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 2'd0); tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 2'd0);
    chk("jr_stall", {3'd0, stall}, 4'd0);
    chk("jr_fwd_rs_d", {2'd0, fwd_rs_d}, 4'd1); tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 2'd0); tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0);
    chk("zero_stall", {3'd0, stall}, 4'd0);
    chk("zero_fwd", {fwd_rs_d, fwd_rt_d}, 4'd0); tick();

    // lw $4 then sw $4: no stall, store data forwarded from W in M
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 1'b0, 2'd0); tick();
    set_d(5'd0, 5'd4, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 2'd0);
    chk("sw_stall", {3'd0, stall}, 4'd0); tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 2'd0); tick();
    chk("sw_fwd_rt_m", {2'd0, fwd_rt_m}, 4'd3); tick();

    // mult then mflo: 5 stall cycles
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 2'b01); tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b1, 2'b00);
    for (int i = 0; i < MULT_CYC; i++) begin
      chk("mult_stall", {3'd0, stall}, 4'd1);
      chk("mult_busy", {3'd0, md_busy}, 4'd1); tick();
    end
    chk("mult_done_stall", {3'd0, stall}, 4'd0);
    chk("mult_done_busy", {3'd0, md_busy}, 4'd0); tick();

    // div then mflo: 10 stall cycles
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 2'b10); tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b1, 2'b00);
    for (int i = 0; i < DIV_CYC; i++) begin
      chk("div_stall", {3'd0, stall}, 4'd1); tick();
    end
    chk("div_done_stall", {3'd0, stall}, 4'd0); tick();

    // div running at count 7: flush keeps it counting, reset clears it
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 2'b10); tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b1, 2'b00);
    flush = 1'b1; #1; tick();
    flush = 1'b0; #1;
    chk("flush_busy", {3'd0, md_busy}, 4'd1);
    chk("flush_stall", {3'd0, stall}, 4'd1);
    do_reset();

    // random instruction streams; a stalled D instruction is held
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 299) == 0) do_reset();
      if (!x_stall) begin
        r = int'($urandom_range(0, 15));
        rs_d = 5'($urandom_range(0, 3));
        rt_d = 5'($urandom_range(0, 3));
        tuse_rs = 2'($urandom_range(0, 3));
        tuse_rt = 2'($urandom_range(0, 3));
        a3_d = 5'($urandom_range(0, 3));
        tnew_d = 2'($urandom_range(0, 2));
        md_d = (r < 4) ? 1'b1 : 1'b0;
        md_start_d = (r == 0) ? 2'b01 : ((r == 1) ? 2'b10 : 2'b00);
      end
      flush = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      #1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
